mem_access_unit: RTL and testbench

//  Memory stage sequencer downstream of the main decoder. Consumes the decoded RAM strobe, direction
//  and access type; runs a MOV/MOC four-phase handshake with the data RAM; steers byte lanes; returns

---
 rtl/mem_access_unit_pkg.sv | 37 +++
 rtl/mem_lane_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 tb/tb_mem_access_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: access codes, FSM states,
// byte-enable masks and the registered request record.
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        ACC_W  = 3'b000,
        ACC_H  = 3'b001,
        ACC_HU = 3'b010,
        ACC_B  = 3'b011,
        ACC_BU = 3'b100
    } acc_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    localparam logic [NUM_LANES-1:0] BE_WORD = 4'b1111;
    localparam logic [NUM_LANES-1:0] BE_HI   = 4'b1100;
    localparam logic [NUM_LANES-1:0] BE_LO   = 4'b0011;
    localparam logic [NUM_LANES-1:0] BE_B0   = 4'b1000;

    typedef struct packed {
        logic                        rw;
        logic [2:0]                  acc;
        logic [1:0]                  lo;
        logic [29:0]                 word;
        logic [NUM_LANES-1:0]        be;
        logic [NUM_LANES*LANE_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: store enables/replication, load lane select
// with sign/zero extension, and the alignment check.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]                  access_type,
    input  logic [1:0]                  addr_lo,
    input  logic [NUM_LANES*LANE_W-1:0] wdata,
    input  logic [NUM_LANES*LANE_W-1:0] rdata_word,
    output logic [NUM_LANES-1:0]        be,
    output logic [NUM_LANES*LANE_W-1:0] wdata_lane,
    output logic [NUM_LANES*LANE_W-1:0] rdata_ext,
    output logic                        misalign
);

    logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
    logic [LANE_W-1:0]                byte_sel;
    logic [2*LANE_W-1:0]              half_sel;

    // Lane 3 holds bits 31:24 and is byte address 0.
    assign lanes    = rdata_word;
    assign byte_sel = lanes[2'd3 - addr_lo];
    assign half_sel = addr_lo[1] ? rdata_word[15:0] : rdata_word[31:16];

    always_comb begin
        be         = BE_WORD;
        wdata_lane = wdata;
        rdata_ext  = rdata_word;
        misalign   = (addr_lo != 2'b00);
        case (access_type)
            ACC_H, ACC_HU: begin
                be         = addr_lo[1] ? BE_LO : BE_HI;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (access_type == ACC_H) ? {{16{half_sel[15]}}, half_sel}
                                                    : {16'h0, half_sel};
                misalign   = addr_lo[0];
            end
            ACC_B, ACC_BU: begin
                be         = BE_B0 >> addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (access_type == ACC_B) ? {{24{byte_sel[7]}}, byte_sel}
                                                    : {24'h0, byte_sel};
                misalign   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: MOV/MOC four-phase handshake with the data RAM,
// pipeline stall generation, timeout abort and load data return.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ram_enable,
    input  logic        rw,
    input  logic [2:0]  access_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic        timeout_err,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_moc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t            state, state_nxt;
    mem_req_t          req_q;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        lane_type;
    logic [1:0]        lane_lo;
    logic [3:0]        lane_be;
    logic [31:0]       lane_wdata;
    logic [31:0]       lane_rdata;
    logic              lane_misalign;
    logic              accept;
    logic              timeout_hit;

    // One aligner serves both phases: live inputs in IDLE, the held request afterwards.
    assign lane_type = (state == IDLE) ? access_type : req_q.acc;
    assign lane_lo   = (state == IDLE) ? addr[1:0]   : req_q.lo;

    mem_lane_align u_align (
        .access_type (lane_type),
        .addr_lo     (lane_lo),
        .wdata       (wdata),
        .rdata_word  (mem_rdata),
        .be          (lane_be),
        .wdata_lane  (lane_wdata),
        .rdata_ext   (lane_rdata),
        .misalign    (lane_misalign)
    );

    assign accept      = (state == IDLE) && ram_enable && !lane_misalign;
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= RELEASE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = REQ;
            REQ:     if (mem_moc) state_nxt = ACK;
                     else if (timeout_hit) state_nxt = RELEASE;
            ACK:     state_nxt = mem_moc ? RELEASE : IDLE;
            RELEASE: if (!mem_moc) state_nxt = IDLE;
            default: state_nxt = RELEASE;
        endcase
    end

    always_comb begin
        stall        = 1'b0;
        done         = 1'b0;
        misalign_err = 1'b0;
        timeout_err  = 1'b0;
        mem_mov      = 1'b0;
        mem_rw       = 1'b0;
        mem_addr     = '0;
        mem_be       = '0;
        mem_wdata    = '0;
        case (state)
            IDLE: begin
                stall        = accept;
                misalign_err = ram_enable && lane_misalign;
            end
            REQ: begin
                stall       = 1'b1;
                mem_mov     = 1'b1;
                mem_rw      = req_q.rw;
                mem_addr    = {req_q.word, 2'b00};
                mem_be      = req_q.be;
                mem_wdata   = req_q.wdata;
                timeout_err = !mem_moc && timeout_hit;
            end
            ACK:     done  = 1'b1;
            RELEASE: stall = ram_enable;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '0;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            if (accept)
                req_q <= '{rw: rw, acc: access_type, lo: addr[1:0], word: addr[31:2],
                           be: lane_be, wdata: lane_wdata};
            if (state == REQ && !mem_moc) cnt <= cnt + 1'b1;
            else                          cnt <= '0;
            if (state == REQ && mem_moc && !req_q.rw) rdata <= lane_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalign, timeout and
// reset-during-access, with a responder that raises mem_moc after a set delay.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ram_enable;
    logic        rw;
    logic [2:0]  access_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign_err;
    logic        timeout_err;
    logic        mem_mov;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_moc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .ram_enable(ram_enable), .rw(rw),
        .access_type(access_type), .addr(addr), .wdata(wdata),
        .stall(stall), .done(done), .rdata(rdata),
        .misalign_err(misalign_err), .timeout_err(timeout_err),
        .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one access from IDLE to done; mem_moc rises moc_dly REQ cycles after mov.
    task automatic run_access(input logic i_rw, input logic [2:0] i_t, input logic [31:0] i_a,
                              input logic [31:0] i_wd, input logic [31:0] word, input int moc_dly,
                              output int stalls, output int done_cyc, output logic [3:0] be_s,
                              output logic [31:0] addr_s, output logic [31:0] wd_s,
                              output logic rw_s);
        int req_cyc = 0;
        ram_enable = 1'b1; rw = i_rw; access_type = i_t; addr = i_a; wdata = i_wd;
        mem_rdata = word;
        stalls = 0; done_cyc = -1; be_s = '0; addr_s = '0; wd_s = '0; rw_s = 1'b0;
        for (int c = 0; c < 20 && done_cyc < 0; c++) begin
            #1;
            if (mem_mov) begin
                if (req_cyc == 0) begin
                    be_s = mem_be; addr_s = mem_addr; wd_s = mem_wdata; rw_s = mem_rw;
                end
                mem_moc = (req_cyc >= moc_dly);
                req_cyc++;
            end else begin
                mem_moc = 1'b0;
            end
            #1;
            if (stall) stalls++;
            if (done) done_cyc = c;
            tick();
        end
        ram_enable = 1'b0;
        mem_moc    = 1'b0;
        if (done_cyc < 0) chk("done_budget", 32'd0, 32'd1);
    endtask

    int          st, dc;
    logic [3:0]  be_s;
    logic [31:0] a_s, wd_s;
    logic        rw_s;
    int          to_cyc, mov_cnt;
    logic        got_done, mov_after;

    initial begin
        reset = 1'b1; ram_enable = 1'b0; rw = 1'b0; access_type = 3'b000;
        addr = '0; wdata = '0; mem_rdata = '0; mem_moc = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_mov", mem_mov, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_errs", {misalign_err, timeout_err}, 0);
        tick();

        // LW with one wait cycle
        run_access(1'b0, 3'b000, 32'h104, 32'h0, 32'hDEADBEEF, 1, st, dc, be_s, a_s, wd_s, rw_s);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_stalls", st, 3);
        chk("lw_done_cyc", dc, 3);
        chk("lw_be", be_s, 4'b1111);
        chk("lw_addr", a_s, 32'h104);
        chk("lw_rw", rw_s, 0);
        chk("lw_done_single", done, 0);

        // LB zero-wait: done two cycles after request
        run_access(1'b0, 3'b011, 32'h103, 32'h0, 32'h112233F0, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("lb_be", be_s, 4'b0001);
        chk("lb_rdata", rdata, 32'hFFFFFFF0);
        chk("lb_done_cyc", dc, 2);
        chk("lb_stalls", st, 2);
        chk("lb_addr", a_s, 32'h100);

        run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h112233F0, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("lbu_rdata", rdata, 32'h000000F0);

        // SH: rdata must keep the previous load result
        run_access(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h55555555, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("sh_be", be_s, 4'b0011);
        chk("sh_wdata", wd_s, 32'hABCDABCD);
        chk("sh_rw", rw_s, 1);
        chk("sh_addr", a_s, 32'h20);
        chk("sh_rdata_hold", rdata, 32'h000000F0);

        run_access(1'b0, 3'b001, 32'h100, 32'h0, 32'h80011234, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("lh_be", be_s, 4'b1100);
        chk("lh_rdata", rdata, 32'hFFFF8001);

        run_access(1'b0, 3'b010, 32'h102, 32'h0, 32'h1234F00D, 1, st, dc, be_s, a_s, wd_s, rw_s);
        chk("lhu_be", be_s, 4'b0011);
        chk("lhu_rdata", rdata, 32'h0000F00D);

        run_access(1'b1, 3'b011, 32'h41, 32'h0000005A, 32'h0, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("sb_be", be_s, 4'b0100);
        chk("sb_wdata", wd_s, 32'h5A5A5A5A);

        run_access(1'b0, 3'b011, 32'h101, 32'h0, 32'h117F3344, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("lb1_be", be_s, 4'b0100);
        chk("lb1_rdata", rdata, 32'h0000007F);

        run_access(1'b1, 3'b000, 32'h80, 32'h01020304, 32'h0, 0, st, dc, be_s, a_s, wd_s, rw_s);
        chk("sw_wdata", wd_s, 32'h01020304);
        chk("sw_rdata_hold", rdata, 32'h0000007F);

        // Misaligned word load: pulse, no bus cycle, no stall
        ram_enable = 1'b1; rw = 1'b0; access_type = 3'b000; addr = 32'h102;
        #1;
        chk("mis_err", misalign_err, 1);
        chk("mis_stall", stall, 0);
        chk("mis_mov", mem_mov, 0);
        ram_enable = 1'b0;
        tick();
        chk("mis_mov_after", mem_mov, 0);
        chk("mis_err_clear", misalign_err, 0);
        chk("mis_rdata_hold", rdata, 32'h0000007F);
        access_type = 3'b001; addr = 32'h101; ram_enable = 1'b1;
        #1;
        chk("mis_h_err", misalign_err, 1);
        ram_enable = 1'b0;
        tick();

        // mem_moc high while IDLE must not produce done
        mem_moc = 1'b1;
        tick();
        chk("idle_moc_done", done, 0);
        chk("idle_moc_stall", stall, 0);
        tick();
        chk("idle_moc_done2", done, 0);
        mem_moc = 1'b0;
        tick();

        // Timeout with TIMEOUT_CYCLES=4: error on the 4th REQ cycle
        ram_enable = 1'b1; rw = 1'b0; access_type = 3'b000; addr = 32'h200;
        to_cyc = -1; mov_cnt = 0; got_done = 1'b0; mov_after = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mem_mov) mov_cnt++;
            if (timeout_err && to_cyc < 0) to_cyc = c;
            if (done) got_done = 1'b1;
            if (c == 5) mov_after = mem_mov;
            tick();
            ram_enable = 1'b0;
        end
        chk("to_cycle", to_cyc, 4);
        chk("to_mov_cycles", mov_cnt, 4);
        chk("to_no_done", got_done, 0);
        chk("to_mov_low", mov_after, 0);
        chk("to_rdata_hold", rdata, 32'h0000007F);

        // Reset while in REQ with mem_moc high; stale moc held 3 more cycles
        ram_enable = 1'b1; rw = 1'b0; access_type = 3'b000; addr = 32'h300;
        mem_rdata = 32'hCAFEF00D;
        tick();
        #1;
        chk("rr_in_req", mem_mov, 1);
        mem_moc = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rr_mov_drop", mem_mov, 0);
        chk("rr_no_done", done, 0);
        chk("rr_rdata", rdata, 0);
        for (int c = 0; c < 3; c++) begin
            chk("rr_stall_moc", stall, 1);
            chk("rr_mov_moc", mem_mov, 0);
            tick();
        end
        mem_moc = 1'b0;
        #1;
        chk("rr_stall_rel", stall, 1);
        chk("rr_no_done2", done, 0);
        tick();
        run_access(1'b0, 3'b000, 32'h300, 32'h0, 32'h0BADC0DE, 1, st, dc, be_s, a_s, wd_s, rw_s);
        chk("rr_after_rdata", rdata, 32'h0BADC0DE);
        chk("rr_after_stalls", st, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
